// File: rtl/alu_mem_seq_if.sv
// Bus interface for alu_mem_seq: enable/rd_wr/addr access strobe, write data,
// registered read data and the result-FIFO status outputs.
interface alu_mem_seq_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
);
  logic                  enable;
  logic                  rd_wr;
  logic [ADDR_W-1:0]     addr;
  logic [DATA_W-1:0]     wr_data;
  logic [DATA_W-1:0]     rd_data;
  logic [2*DATA_W-1:0]   res_out;
  logic                  res_valid;
  logic                  busy;

  modport master (
    output enable, rd_wr, addr, wr_data,
    input  rd_data, res_out, res_valid, busy
  );

  modport slave (
    input  enable, rd_wr, addr, wr_data,
    output rd_data, res_out, res_valid, busy
  );
endinterface

// File: rtl/alu_mem_seq.sv
// Memory-mapped register file with a sequential ALU and a result FIFO.
// Host writes A, B and OPER, triggers execute through CTRL, and reads results
// back via RES_LO (peek) and RES_HI (pop). MUL runs as a one-bit-per-cycle
// shift-add; all other ops take a single EXEC cycle.
// Optional feature: define ALU_MEM_SAT_EN to make ADD/SUB saturate to DATA_W
// bits, with result bit DATA_W flagging that saturation occurred.
module alu_mem_seq #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 3,
  parameter int RES_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  alu_mem_seq_if.slave bus
);

  localparam int RES_W = 2 * DATA_W;
  localparam int SH_W  = $clog2(DATA_W);
  localparam int MC_W  = $clog2(DATA_W + 1);
  localparam int PTR_W = $clog2(RES_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_PUSH = 2'd2
  } state_t;

  state_t state_r, next_state_s;

  // host-visible registers and flags
  logic [DATA_W-1:0] a_r, b_r, rd_data_r;
  logic [2:0]        oper_r;
  logic              err_r, drop_r, busy_r;

  // working copies of the running op
  logic [DATA_W-1:0] a_w_r, b_w_r, mplier_r;
  logic [2:0]        op_w_r;
  logic [RES_W-1:0]  acc_r, mcand_r, res_r;
  logic [MC_W-1:0]   cnt_r;

  // result FIFO
  logic [RES_W-1:0]  mem_r [RES_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_r, rd_ptr_r, rd_ptr_next_s;
  logic [CNT_W-1:0]  count_r, count_next_s;
  logic [RES_W-1:0]  res_out_r, head_next_s;
  logic              res_valid_r;

  // decoded bus events
  logic wr_en_s, rd_en_s, exec_req_s, clr_req_s, exec_ok_s;
  logic full_s, empty_s, push_s, pop_s, op_mul_s, mul_last_s;

  logic [DATA_W:0]     sum_s, diff_s;
  logic [RES_W-1:0]    mul_acc_next_s, alu_res_s;
  logic [DATA_W-1:0]   rd_mux_s;

  assign wr_en_s    = bus.enable && bus.rd_wr;
  assign rd_en_s    = bus.enable && !bus.rd_wr;
  assign exec_req_s = wr_en_s && (bus.addr == ADDR_W'(3)) && bus.wr_data[0];
  assign clr_req_s  = wr_en_s && (bus.addr == ADDR_W'(3)) && bus.wr_data[1];
  assign full_s     = (count_r == CNT_W'(RES_DEPTH));
  assign empty_s    = (count_r == {CNT_W{1'b0}});
  assign exec_ok_s  = exec_req_s && (state_r == S_IDLE) && !full_s;
  assign push_s     = (state_r == S_PUSH);
  assign pop_s      = rd_en_s && (bus.addr == ADDR_W'(6)) && !empty_s;
  assign op_mul_s   = (op_w_r == 3'd2);
  assign mul_last_s = (cnt_r == MC_W'(DATA_W - 1));

  // FSM state register; busy mirrors "not idle" one register stage in
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= S_IDLE;
      busy_r  <= 1'b0;
    end else begin
      state_r <= next_state_s;
      busy_r  <= (next_state_s != S_IDLE);
    end
  end

  // FSM next-state: MUL stays in EXEC for DATA_W cycles, others for one
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (exec_ok_s) next_state_s = S_EXEC;
        else           next_state_s = S_IDLE;
      end
      S_EXEC: begin
        if (!op_mul_s || mul_last_s) next_state_s = S_PUSH;
        else                         next_state_s = S_EXEC;
      end
      S_PUSH:  next_state_s = S_IDLE;
      default: next_state_s = S_IDLE;
    endcase
  end

  // ALU result for the working operands; MUL yields the accumulator after this step
  always_comb begin
    sum_s          = {1'b0, a_w_r} + {1'b0, b_w_r};
    diff_s         = {1'b0, a_w_r} - {1'b0, b_w_r};
    mul_acc_next_s = mplier_r[0] ? (acc_r + mcand_r) : acc_r;
    alu_res_s      = {RES_W{1'b0}};
    case (op_w_r)
`ifdef ALU_MEM_SAT_EN
      3'd0: begin
        if (sum_s[DATA_W]) alu_res_s = {{(DATA_W-1){1'b0}}, 1'b1, {DATA_W{1'b1}}};
        else               alu_res_s = {{(DATA_W-1){1'b0}}, sum_s};
      end
      3'd1: begin
        if (diff_s[DATA_W]) alu_res_s = {{(DATA_W-1){1'b0}}, 1'b1, {DATA_W{1'b0}}};
        else                alu_res_s = {{(DATA_W-1){1'b0}}, diff_s};
      end
`else
      3'd0: alu_res_s = {{(DATA_W-1){1'b0}}, sum_s};
      3'd1: alu_res_s = {{(DATA_W-1){1'b0}}, diff_s};
`endif
      3'd2: alu_res_s = mul_acc_next_s;
      3'd3: alu_res_s = {{DATA_W{1'b0}}, a_w_r & b_w_r};
      3'd4: alu_res_s = {{DATA_W{1'b0}}, a_w_r | b_w_r};
      3'd5: alu_res_s = {{DATA_W{1'b0}}, a_w_r ^ b_w_r};
      3'd6: alu_res_s = {{DATA_W{1'b0}}, a_w_r << b_w_r[SH_W-1:0]};
      3'd7: alu_res_s = {{DATA_W{1'b0}}, a_w_r >> b_w_r[SH_W-1:0]};
      default: alu_res_s = {RES_W{1'b0}};
    endcase
  end

  // snapshot operands on accepted execute, then step the op while in EXEC
  always_ff @(posedge clk) begin
    if (rst) begin
      a_w_r    <= {DATA_W{1'b0}};
      b_w_r    <= {DATA_W{1'b0}};
      op_w_r   <= 3'd0;
      acc_r    <= {RES_W{1'b0}};
      mcand_r  <= {RES_W{1'b0}};
      mplier_r <= {DATA_W{1'b0}};
      cnt_r    <= {MC_W{1'b0}};
      res_r    <= {RES_W{1'b0}};
    end else if (exec_ok_s) begin
      a_w_r    <= a_r;
      b_w_r    <= b_r;
      op_w_r   <= oper_r;
      acc_r    <= {RES_W{1'b0}};
      mcand_r  <= {{DATA_W{1'b0}}, a_r};
      mplier_r <= b_r;
      cnt_r    <= {MC_W{1'b0}};
    end else if (state_r == S_EXEC) begin
      acc_r    <= mul_acc_next_s;
      mcand_r  <= mcand_r << 1;
      mplier_r <= mplier_r >> 1;
      cnt_r    <= cnt_r + MC_W'(1);
      res_r    <= alu_res_s;
    end
  end

  // FIFO bookkeeping and the head value as it will look after this edge
  always_comb begin
    case ({push_s, pop_s})
      2'b10:   count_next_s = count_r + CNT_W'(1);
      2'b01:   count_next_s = count_r - CNT_W'(1);
      default: count_next_s = count_r;
    endcase
    if (pop_s) rd_ptr_next_s = rd_ptr_r + PTR_W'(1);
    else       rd_ptr_next_s = rd_ptr_r;
    if (count_next_s == {CNT_W{1'b0}})
      head_next_s = {RES_W{1'b0}};
    else if (push_s && (rd_ptr_next_s == wr_ptr_r))
      head_next_s = res_r;
    else
      head_next_s = mem_r[rd_ptr_next_s];
  end

  // FIFO storage; PUSH only happens with room, since execute needs a free slot
  always_ff @(posedge clk) begin
    if (push_s) mem_r[wr_ptr_r] <= res_r;
  end

  // FIFO pointers, count and registered head/valid outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r    <= {PTR_W{1'b0}};
      rd_ptr_r    <= {PTR_W{1'b0}};
      count_r     <= {CNT_W{1'b0}};
      res_out_r   <= {RES_W{1'b0}};
      res_valid_r <= 1'b0;
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      rd_ptr_r    <= rd_ptr_next_s;
      count_r     <= count_next_s;
      res_out_r   <= head_next_s;
      res_valid_r <= (count_next_s != {CNT_W{1'b0}});
    end
  end

  // read mux over the register map; unmapped and write-only addresses read 0
  always_comb begin
    case (bus.addr)
      ADDR_W'(0): rd_mux_s = a_r;
      ADDR_W'(1): rd_mux_s = b_r;
      ADDR_W'(2): rd_mux_s = {{(DATA_W-3){1'b0}}, oper_r};
      ADDR_W'(4): rd_mux_s = {{(DATA_W-5){1'b0}}, drop_r, err_r, full_s, res_valid_r, busy_r};
      ADDR_W'(5): rd_mux_s = res_out_r[DATA_W-1:0];
      ADDR_W'(6): rd_mux_s = res_out_r[RES_W-1:DATA_W];
      default:    rd_mux_s = {DATA_W{1'b0}};
    endcase
  end

  // host register writes, sticky flags and registered read data
  always_ff @(posedge clk) begin
    if (rst) begin
      a_r       <= {DATA_W{1'b0}};
      b_r       <= {DATA_W{1'b0}};
      oper_r    <= 3'd0;
      err_r     <= 1'b0;
      drop_r    <= 1'b0;
      rd_data_r <= {DATA_W{1'b0}};
    end else begin
      if (wr_en_s && (bus.addr == ADDR_W'(0))) a_r    <= bus.wr_data;
      if (wr_en_s && (bus.addr == ADDR_W'(1))) b_r    <= bus.wr_data;
      if (wr_en_s && (bus.addr == ADDR_W'(2))) oper_r <= bus.wr_data[2:0];
      if (clr_req_s) begin
        err_r  <= 1'b0;
        drop_r <= 1'b0;
      end
      // a new rejected execute in the same write wins over the clear
      if (exec_req_s && (state_r != S_IDLE)) err_r  <= 1'b1;
      else if (exec_req_s && full_s)         drop_r <= 1'b1;
      if (rd_en_s) rd_data_r <= rd_mux_s;
    end
  end

  assign bus.rd_data   = rd_data_r;
  assign bus.res_out   = res_out_r;
  assign bus.res_valid = res_valid_r;
  assign bus.busy      = busy_r;

endmodule

// File: tb/tb_alu_mem_seq.sv
// Directed self-checking bench for alu_mem_seq (DATA_W=8, RES_DEPTH=4).
module tb_alu_mem_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  logic [7:0]  rd;
  logic [7:0]  fifo_exp [4];

  always #5 clk = ~clk;

  alu_mem_seq_if #(.DATA_W(8), .ADDR_W(3)) bus_if ();

  alu_mem_seq #(.DATA_W(8), .ADDR_W(3), .RES_DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [7:0] d);
    @(negedge clk);
    bus_if.enable = 1'b1; bus_if.rd_wr = 1'b1; bus_if.addr = a; bus_if.wr_data = d;
    @(negedge clk);
    bus_if.enable = 1'b0; bus_if.rd_wr = 1'b0;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [7:0] d);
    @(negedge clk);
    bus_if.enable = 1'b1; bus_if.rd_wr = 1'b0; bus_if.addr = a;
    @(negedge clk);
    bus_if.enable = 1'b0;
    d = bus_if.rd_data;
  endtask

  task automatic wait_neg(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic wait_valid(input int max);
    int n = 0;
    while (!bus_if.res_valid && n < max) begin
      @(negedge clk);
      n++;
    end
    check("wait_valid_timeout", {15'd0, bus_if.res_valid}, 16'd1);
  endtask

  initial begin
    bus_if.enable = 1'b0; bus_if.rd_wr = 1'b0; bus_if.addr = 3'd0; bus_if.wr_data = 8'd0;
    wait_neg(2);
    rst = 1'b0;

    // reset state
    check("rst_rd_data",   {8'd0, bus_if.rd_data}, 16'd0);
    check("rst_res_out",   bus_if.res_out, 16'd0);
    check("rst_res_valid", {15'd0, bus_if.res_valid}, 16'd0);
    check("rst_busy",      {15'd0, bus_if.busy}, 16'd0);
    bus_read(3'd4, rd); check("rst_status", {8'd0, rd}, 16'd0);

    // ADD 200+100 with latency N+3
    bus_write(3'd0, 8'd200);
    bus_write(3'd1, 8'd100);
    bus_write(3'd2, 8'd0);
    bus_read(3'd0, rd); check("readback_a", {8'd0, rd}, 16'd200);
    bus_write(3'd3, 8'h01);
    check("add_busy_n1",  {15'd0, bus_if.busy}, 16'd1);
    check("add_valid_n1", {15'd0, bus_if.res_valid}, 16'd0);
    @(negedge clk);
    check("add_valid_n2", {15'd0, bus_if.res_valid}, 16'd0);
    @(negedge clk);
    check("add_valid_n3", {15'd0, bus_if.res_valid}, 16'd1);
    check("add_busy_n3",  {15'd0, bus_if.busy}, 16'd0);
`ifdef ALU_MEM_SAT_EN
    check("add_res", bus_if.res_out, 16'h01FF);
    bus_read(3'd5, rd); check("add_res_lo", {8'd0, rd}, 16'h00FF);
`else
    check("add_res", bus_if.res_out, 16'h012C);
    bus_read(3'd5, rd); check("add_res_lo", {8'd0, rd}, 16'h002C);
`endif
    bus_read(3'd4, rd); check("add_status", {8'd0, rd}, 16'h0002);
    bus_read(3'd6, rd); check("add_res_hi", {8'd0, rd}, 16'h0001);
    check("add_popped", {15'd0, bus_if.res_valid}, 16'd0);

    // MUL 255*255, busy through 8 EXEC cycles plus PUSH
    bus_write(3'd0, 8'd255);
    bus_write(3'd1, 8'd255);
    bus_write(3'd2, 8'd2);
    bus_write(3'd3, 8'h01);
    for (int i = 0; i < 9; i++) begin
      check("mul_busy",    {15'd0, bus_if.busy}, 16'd1);
      check("mul_pending", {15'd0, bus_if.res_valid}, 16'd0);
      @(negedge clk);
    end
    check("mul_valid", {15'd0, bus_if.res_valid}, 16'd1);
    check("mul_res",   bus_if.res_out, 16'hFE01);
    bus_read(3'd5, rd); check("mul_res_lo", {8'd0, rd}, 16'h0001);
    bus_read(3'd6, rd); check("mul_res_hi", {8'd0, rd}, 16'h00FE);
    check("mul_popped", {15'd0, bus_if.res_valid}, 16'd0);

    // SUB 100-200 underflow
    bus_write(3'd0, 8'd100);
    bus_write(3'd1, 8'd200);
    bus_write(3'd2, 8'd1);
    bus_write(3'd3, 8'h01);
    wait_neg(2);
`ifdef ALU_MEM_SAT_EN
    check("sub_res", bus_if.res_out, 16'h0100);
`else
    check("sub_res", bus_if.res_out, 16'h019C);
`endif
    bus_read(3'd6, rd); check("sub_res_hi", {8'd0, rd}, 16'h0001);

    // fill FIFO with logic/shift ops, fifth execute is dropped
    fifo_exp[0] = 8'h02; fifo_exp[1] = 8'hCB; fifo_exp[2] = 8'hC9; fifo_exp[3] = 8'h0C;
    bus_write(3'd0, 8'hC3);
    bus_write(3'd1, 8'h0A);
    for (int i = 0; i < 5; i++) begin
      bus_write(3'd2, 8'(3 + i));
      bus_write(3'd3, 8'h01);
      wait_neg(2);
    end
    check("fill_busy", {15'd0, bus_if.busy}, 16'd0);
    bus_read(3'd4, rd); check("fill_status", {8'd0, rd}, 16'h0016);
    for (int i = 0; i < 4; i++) begin
      bus_read(3'd5, rd); check("fifo_lo", {8'd0, rd}, {8'd0, fifo_exp[i]});
      bus_read(3'd6, rd); check("fifo_hi", {8'd0, rd}, 16'd0);
    end
    check("fifo_drained", {15'd0, bus_if.res_valid}, 16'd0);
    bus_write(3'd3, 8'h02);
    bus_read(3'd4, rd); check("drop_cleared", {8'd0, rd}, 16'd0);

    // execute during a running MUL; operand write while busy is harmless
    bus_write(3'd0, 8'd3);
    bus_write(3'd1, 8'd5);
    bus_write(3'd2, 8'd2);
    bus_write(3'd3, 8'h01);
    bus_write(3'd0, 8'd7);
    bus_write(3'd3, 8'h01);
    bus_read(3'd4, rd); check("err_status", {8'd0, rd}, 16'h0009);
    wait_valid(20);
    check("err_mul_res", bus_if.res_out, 16'h000F);
    bus_write(3'd3, 8'h02);
    bus_read(3'd4, rd); check("err_cleared", {8'd0, rd}, 16'h0002);
    bus_read(3'd6, rd); check("err_pop", {8'd0, rd}, 16'd0);
    wait_neg(12);
    check("no_second_op", {15'd0, bus_if.res_valid}, 16'd0);

    // reset three cycles into a MUL
    bus_write(3'd0, 8'd9);
    bus_write(3'd1, 8'd9);
    bus_write(3'd3, 8'h01);
    wait_neg(2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mul_busy",  {15'd0, bus_if.busy}, 16'd0);
    check("rst_mul_valid", {15'd0, bus_if.res_valid}, 16'd0);
    check("rst_mul_res",   bus_if.res_out, 16'd0);
    bus_read(3'd0, rd); check("rst_a",      {8'd0, rd}, 16'd0);
    bus_read(3'd1, rd); check("rst_b",      {8'd0, rd}, 16'd0);
    bus_read(3'd2, rd); check("rst_oper",   {8'd0, rd}, 16'd0);
    bus_read(3'd4, rd); check("rst_status2",{8'd0, rd}, 16'd0);
    wait_neg(12);
    check("rst_no_push", {15'd0, bus_if.res_valid}, 16'd0);

    // pop of an empty FIFO, then a normal op still lands correctly
    bus_write(3'd0, 8'h5A);
    bus_read(3'd0, rd); check("pre_empty_rd", {8'd0, rd}, 16'h005A);
    bus_read(3'd6, rd); check("empty_pop_rd", {8'd0, rd}, 16'd0);
    check("empty_pop_valid", {15'd0, bus_if.res_valid}, 16'd0);
    bus_write(3'd0, 8'd1);
    bus_write(3'd1, 8'd2);
    bus_write(3'd3, 8'h01);
    wait_valid(10);
    check("after_empty_res", bus_if.res_out, 16'h0003);
    bus_read(3'd4, rd); check("after_empty_status", {8'd0, rd}, 16'h0002);
    bus_read(3'd6, rd); check("after_empty_pop", {8'd0, rd}, 16'd0);
    check("after_empty_drained", {15'd0, bus_if.res_valid}, 16'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
